jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller that is the DUT end of the JTAG agent BFM in the jtag bench. The agent drives `tms`/`tdi` and samples `tdo`. The block implements the 16-state TAP FSM, a 4-bit instruction register, and three data registers (IDCODE, BYPASS, USER). The USER register exposes a parallel capture/update port to surrounding logic. All logic runs on one clock that the bench treats as TCK.

---
 rtl/jtag_tap_ctrl.sv | 134 +++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register and
// IDCODE / BYPASS / USER data registers with a parallel USER capture/update port.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1A2B_3C4D,
  parameter int          USER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [3:0]            tap_state,
  output logic [IR_WIDTH-1:0]   ir,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_upd
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0, EX1_DR   = 4'h1, SH_DR    = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EX2_IR   = 4'h8, EX1_IR   = 4'h9, SH_IR    = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_e;

  tap_state_e            state_q, state_d, state_nxt;
  logic                  hold_q;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
  logic [31:0]           dr_sr_q, dr_sr_d;
  logic [31:0]           dr_shift;
  logic [4:0]            dr_msb;
  logic [USER_WIDTH-1:0] user_out_q, user_out_d;
  logic                  user_upd_q, user_upd_d;
  logic                  sel_idcode, sel_user;

  assign sel_idcode = (ir_q == IR_WIDTH'(1));
  assign sel_user   = (ir_q == IR_WIDTH'(8));

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:      state_nxt = tms ? TLR      : RTI;
      RTI:      state_nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
    // First edge after reset release keeps the FSM parked in TLR.
    state_d = hold_q ? TLR : state_nxt;
  end

  always_comb begin
    if (sel_idcode)    dr_msb = 5'd31;
    else if (sel_user) dr_msb = 5'(USER_WIDTH - 1);
    else               dr_msb = 5'd0;
    dr_shift         = {1'b0, dr_sr_q[31:1]};
    dr_shift[dr_msb] = tdi;
  end

  always_comb begin
    ir_d       = ir_q;
    ir_sr_d    = ir_sr_q;
    dr_sr_d    = dr_sr_q;
    user_out_d = user_out_q;
    user_upd_d = 1'b0;
    case (state_q)
      TLR:    ir_d    = IR_WIDTH'(1);
      CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d    = ir_sr_q;
      CAP_DR: begin
        if (sel_idcode)    dr_sr_d = IDCODE_VAL;
        else if (sel_user) dr_sr_d = 32'(user_in);
        else               dr_sr_d = 32'd0;
      end
      SH_DR:  dr_sr_d = dr_shift;
      UPD_DR: begin
        if (sel_user) begin
          user_out_d = dr_sr_q[USER_WIDTH-1:0];
          user_upd_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TLR;
      hold_q     <= 1'b1;
      ir_q       <= IR_WIDTH'(1);
      ir_sr_q    <= '0;
      dr_sr_q    <= '0;
      user_out_q <= '0;
      user_upd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= 1'b0;
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      dr_sr_q    <= dr_sr_d;
      user_out_q <= user_out_d;
      user_upd_q <= user_upd_d;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == SH_IR)      tdo = ir_sr_q[0];
    else if (state_q == SH_DR) tdo = dr_sr_q[0];
  end

  assign tdo_en    = (state_q == SH_IR) || (state_q == SH_DR);
  assign tap_state = state_q;
  assign ir        = ir_q;
  assign user_out  = user_out_q;
  assign user_upd  = user_upd_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: a queue-based model of the TAP shift paths is
// compared against the DUT every cycle, plus directed scans with literal results.
module tb_jtag_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       tdo, tdo_en, user_upd;
  logic [3:0] tap_state, ir;
  logic [7:0] user_in = 8'h00;
  logic [7:0] user_out;

  jtag_tap_ctrl dut (
    .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tap_state(tap_state), .ir(ir), .user_in(user_in), .user_out(user_out),
    .user_upd(user_upd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  logic chk_en = 1'b0;

  // Model: state by code, shift registers as LSB-first bit queues.
  logic [3:0] m_state;
  logic [3:0] m_ir;
  logic [7:0] m_user_out;
  logic       m_upd;
  logic       m_hold;
  bit         ir_bits[$];
  bit         dr_bits[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] next_state(input logic [3:0] s, input logic t);
    case (s)
      4'hF: return t ? 4'hF : 4'hC;
      4'hC: return t ? 4'h7 : 4'hC;
      4'h7: return t ? 4'h4 : 4'h6;
      4'h6: return t ? 4'h1 : 4'h2;
      4'h2: return t ? 4'h1 : 4'h2;
      4'h1: return t ? 4'h5 : 4'h3;
      4'h3: return t ? 4'h0 : 4'h3;
      4'h0: return t ? 4'h5 : 4'h2;
      4'h5: return t ? 4'h7 : 4'hC;
      4'h4: return t ? 4'hF : 4'hE;
      4'hE: return t ? 4'h9 : 4'hA;
      4'hA: return t ? 4'h9 : 4'hA;
      4'h9: return t ? 4'hD : 4'hB;
      4'hB: return t ? 4'h8 : 4'hB;
      4'h8: return t ? 4'hD : 4'hA;
      default: return t ? 4'h7 : 4'hC;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 4'hF; m_ir = 4'h1; m_user_out = 8'h00; m_upd = 1'b0; m_hold = 1'b1;
    ir_bits.delete(); dr_bits.delete();
  endtask

  task automatic model_update(input logic t, input logic d);
    logic [31:0] v;
    int len;
    if (m_hold) begin
      m_hold = 1'b0; m_state = 4'hF; m_ir = 4'h1; m_upd = 1'b0;
      return;
    end
    m_upd = 1'b0;
    case (m_state)
      4'hF: m_ir = 4'h1;
      4'hE: begin
        ir_bits.delete();
        ir_bits.push_back(1'b1);
        for (int i = 1; i < 4; i++) ir_bits.push_back(1'b0);
      end
      4'hA: begin
        if (ir_bits.size() > 0) void'(ir_bits.pop_front());
        ir_bits.push_back(d);
      end
      4'hD: begin
        m_ir = 4'h0;
        for (int i = 0; i < 4 && i < ir_bits.size(); i++) m_ir[i] = ir_bits[i];
      end
      4'h6: begin
        if (m_ir == 4'h1)      begin len = 32; v = 32'h1A2B_3C4D; end
        else if (m_ir == 4'h8) begin len = 8;  v = 32'(user_in); end
        else                   begin len = 1;  v = 32'd0; end
        dr_bits.delete();
        for (int i = 0; i < len; i++) dr_bits.push_back(v[i]);
      end
      4'h2: begin
        if (dr_bits.size() > 0) void'(dr_bits.pop_front());
        dr_bits.push_back(d);
      end
      4'h5: begin
        if (m_ir == 4'h8) begin
          m_user_out = 8'h00;
          for (int i = 0; i < 8 && i < dr_bits.size(); i++) m_user_out[i] = dr_bits[i];
          m_upd = 1'b1;
        end
      end
      default: ;
    endcase
    m_state = next_state(m_state, t);
  endtask

  function automatic logic m_tdo();
    if (m_state == 4'hA && ir_bits.size() > 0) return ir_bits[0];
    if (m_state == 4'h2 && dr_bits.size() > 0) return dr_bits[0];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tap_state", 32'(tap_state), 32'(m_state));
      chk("ir",        32'(ir),        32'(m_ir));
      chk("tdo",       32'(tdo),       32'(m_tdo()));
      chk("tdo_en",    32'(tdo_en),    32'((m_state == 4'hA) || (m_state == 4'h2)));
      chk("user_out",  32'(user_out),  32'(m_user_out));
      chk("user_upd",  32'(user_upd),  32'(m_upd));
      if (user_upd) upd_cnt++;
    end
  end

  // One TCK edge; b is the tdo bit presented before the edge.
  task automatic step(input logic t, input logic d, output logic b);
    tms = t; tdi = d;
    b = tdo;
    @(posedge clk);
    model_update(t, d);
    #1;
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
    logic b;
    step(1, 0, b); step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, v[i], b);
      o[i] = b;
    end
    step(1, 0, b); step(0, 0, b);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] v, input int pause_at,
                         output logic [31:0] o);
    logic b;
    o = 32'd0;
    step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) || (pause_at != 0 && i == pause_at - 1), v[i], b);
      o[i] = b;
      if (pause_at != 0 && i == pause_at - 1 && i != n - 1) begin
        step(0, 0, b);
        repeat (5) step(0, 0, b);
        step(1, 0, b);
        step(0, 0, b);
      end
    end
    step(1, 0, b); step(0, 0, b);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [3:0]  o4;
  logic [31:0] o32;
  logic        bb;
  int          plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  logic [7:0]  pbits[16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                             8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  logic [3:0]  pcode[16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                             4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

  initial begin
    model_reset();
    #1 chk_en = 1'b1;
    apply_reset();

    // Idle after reset.
    step(1, 0, bb);
    repeat (3) step(0, 0, bb);
    chk("idle_state", 32'(tap_state), 32'hC);
    chk("idle_ir", 32'(ir), 32'h1);
    chk("idle_tdo_en", 32'(tdo_en), 32'h0);

    scan_dr(32, 32'h0, 0, o32);
    chk("idcode_read", o32, 32'h1A2B_3C4D);

    scan_ir(4'hF, o4);
    chk("ir_capture_f", 32'(o4), 32'h1);
    chk("ir_bypass", 32'(ir), 32'hF);
    scan_dr(16, 32'h0000_BEEF, 0, o32);
    chk("bypass_stream", 32'(o32[15:0]), 32'h7DDE);

    scan_ir(4'h8, o4);
    chk("ir_capture_8", 32'(o4), 32'h1);
    chk("ir_user", 32'(ir), 32'h8);
    user_in = 8'h3C;
    upd_cnt = 0;
    scan_dr(8, 32'hA5, 0, o32);
    chk("user_capture", 32'(o32[7:0]), 32'h3C);
    chk("user_out", 32'(user_out), 32'hA5);
    chk("user_upd_high", 32'(user_upd), 32'h1);
    step(0, 0, bb);
    chk("user_upd_low", 32'(user_upd), 32'h0);
    chk("user_upd_count", 32'(upd_cnt), 32'h1);

    user_in = 8'h5A;
    upd_cnt = 0;
    scan_dr(8, 32'hA5, 4, o32);
    chk("pause_capture", 32'(o32[7:0]), 32'h5A);
    step(0, 0, bb);
    chk("pause_user_out", 32'(user_out), 32'hA5);
    chk("pause_upd_count", 32'(upd_cnt), 32'h1);

    // Reset in the middle of a USER shift.
    upd_cnt = 0;
    step(1, 0, bb); step(0, 0, bb); step(0, 0, bb);
    repeat (3) step(0, 1, bb);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_state", 32'(tap_state), 32'hF);
    chk("rst_ir", 32'(ir), 32'h1);
    chk("rst_user_out", 32'(user_out), 32'h0);
    chk("rst_user_upd", 32'(user_upd), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step(1, 0, bb);
    repeat (4) step(1, 0, bb);
    repeat (3) step(0, 0, bb);
    chk("rst_no_strobe", 32'(upd_cnt), 32'h0);
    chk("rst_user_out_kept", 32'(user_out), 32'h0);

    // Five tms=1 edges reach TLR from every state.
    for (int s = 0; s < 16; s++) begin
      repeat (5) step(1, 0, bb);
      for (int k = 0; k < plen[s]; k++) step(pbits[s][k], 0, bb);
      chk("nav_state", 32'(tap_state), 32'(pcode[s]));
      repeat (5) step(1, 0, bb);
      chk("five_tms_tlr", 32'(tap_state), 32'hF);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
